// File: rtl/palindrome_detect_n.sv
// Serial palindrome detector over the newest L accepted bits, L selectable at runtime in 2..MAX_LEN.
// Optional saturating match counter enabled by defining PALINDROME_DETECT_CNT_EN.
module palindrome_detect_n #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_i,
  input  logic             valid_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             palindrome_o,
  output logic [CNT_W-1:0] pal_count_o
);

  localparam int FILL_W = $clog2(MAX_LEN);

  logic [MAX_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [LEN_W-1:0]   r_len_q;

  logic [LEN_W-1:0]   w_le;
  logic [MAX_LEN-1:0] w_win;
  logic               w_match;
  logic               w_same_len;
  logic               w_warm;

  // Clamp the requested length into the supported range
  always_comb begin
    w_le = len_i;
    if (len_i < LEN_W'(2)) begin
      w_le = LEN_W'(2);
    end else if (len_i > LEN_W'(MAX_LEN)) begin
      w_le = LEN_W'(MAX_LEN);
    end else begin
      w_le = len_i;
    end
  end

  assign w_win = {r_hist, x_i};

  // Mirror compare for every legal length with constant indices, then select by w_le
  always_comb begin
    w_match = 1'b0;
    for (int l = 2; l <= MAX_LEN; l++) begin
      if (w_le == LEN_W'(l)) begin
        w_match = 1'b1;
        for (int k = 0; k < l / 2; k++) begin
          w_match = w_match & (w_win[k] == w_win[l-1-k]);
        end
      end else begin
        w_match = w_match;
      end
    end
  end

  assign w_same_len   = (w_le == r_len_q);
  assign w_warm       = (LEN_W'(r_fill) >= (w_le - LEN_W'(1)));
  assign palindrome_o = valid_i & w_same_len & w_warm & w_match;

  // History, fill level and active length; a length change restarts warm-up keeping the current bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_len_q <= LEN_W'(MAX_LEN);
    end else if (valid_i) begin
      r_hist <= w_win[MAX_LEN-2:0];
      if (w_same_len) begin
        if (r_fill == FILL_W'(MAX_LEN - 1)) begin
          r_fill <= r_fill;
        end else begin
          r_fill <= r_fill + FILL_W'(1);
        end
        r_len_q <= r_len_q;
      end else begin
        r_fill  <= FILL_W'(1);
        r_len_q <= w_le;
      end
    end else begin
      r_hist  <= r_hist;
      r_fill  <= r_fill;
      r_len_q <= r_len_q;
    end
  end

`ifdef PALINDROME_DETECT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of cycles with a detected palindrome
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (palindrome_o && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign pal_count_o = r_cnt;
`else
  assign pal_count_o = '0;
`endif

endmodule

// File: tb/tb_palindrome_detect_n.sv
// Directed table-driven bench for palindrome_detect_n (MAX_LEN=8, CNT_W=4).
module tb_palindrome_detect_n;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             x_i;
  logic             valid_i;
  logic [LEN_W-1:0] len_i;
  logic             palindrome_o;
  logic [CNT_W-1:0] pal_count_o;

  palindrome_detect_n #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .x_i          (x_i),
    .valid_i      (valid_i),
    .len_i        (len_i),
    .palindrome_o (palindrome_o),
    .pal_count_o  (pal_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             x;
    logic             v;
    logic [LEN_W-1:0] len;
    logic             exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  function automatic void add(input logic rst, input logic x, input logic v,
                              input logic [LEN_W-1:0] len, input logic exp);
    vec_t e;
    e.rst = rst; e.x = x; e.v = v; e.len = len; e.exp = exp;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_model();
`ifdef PALINDROME_DETECT_CNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  // Called at posedge+1; leaves the bench at the next posedge+1 with history cleared
  task automatic do_reset(input string name);
    reset   = 1'b0;
    valid_i = 1'b1;
    x_i     = 1'b1;
    len_i   = 4'd2;
    #2;
    check({name, " rst pal"}, int'(palindrome_o), 0);
    check({name, " rst cnt"}, int'(pal_count_o), 0);
    valid_i = 1'b0;
    #1;
    reset   = 1'b1;
    exp_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input logic x, input logic v,
                       input logic [LEN_W-1:0] len, input logic exp);
    x_i = x; valid_i = v; len_i = len;
    @(negedge clk);
    check({name, " pal"}, int'(palindrome_o), int'(exp));
    check({name, " cnt"}, int'(pal_count_o), cnt_model());
    @(posedge clk);
    if (exp && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
  endtask

  initial begin
    // L=3: 1,0,1,1,0,0
    add(1,1,1,3,0); add(0,0,1,3,0); add(0,1,1,3,1); add(0,1,1,3,0); add(0,0,1,3,0); add(0,0,1,3,0);
    // L=4: 1,0,0,1,1,0 then 0,1,1,0 (windows 1001, 0110, 1001, 0110 match)
    add(1,1,1,4,0); add(0,0,1,4,0); add(0,0,1,4,0); add(0,1,1,4,1); add(0,1,1,4,0); add(0,0,1,4,1);
    add(0,0,1,4,0); add(0,1,1,4,1); add(0,1,1,4,0); add(0,0,1,4,1);
    // L=5 warm-up over reset zeros
    add(1,0,1,5,0); add(0,0,1,5,0); add(0,0,1,5,0); add(0,0,1,5,0); add(0,0,1,5,1);
    // Bubbles hold history
    add(1,1,1,3,0); add(0,1,0,3,0); add(0,1,0,3,0); add(0,1,0,3,0); add(0,0,1,3,0); add(0,1,1,3,1);
    // 8 zeros at L=3, then change to L=2
    add(1,0,1,3,0); add(0,0,1,3,0);
    for (int i = 0; i < 6; i++) add(0,0,1,3,1);
    add(0,0,1,2,0); add(0,0,1,2,1); add(0,1,1,2,0); add(0,1,1,2,1);
    // len 0/1 behave as L=2 with no length change
    add(0,1,1,0,1); add(0,0,1,1,0); add(0,0,1,1,1);
    // len 15 behaves as L=8; window 0,1,1,0,0,1,1,0
    add(0,0,1,15,0); add(0,1,1,15,0); add(0,1,1,15,0); add(0,0,1,15,0); add(0,0,1,15,0);
    add(0,1,1,15,0); add(0,1,1,15,0); add(0,0,1,15,1); add(0,0,1,15,0); add(0,1,1,8,1);

    reset = 1'b0; x_i = 1'b1; valid_i = 1'b1; len_i = 4'd3;
    #1;
    check("init pal", int'(palindrome_o), 0);
    check("init cnt", int'(pal_count_o), 0);
    #3;
    valid_i = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset($sformatf("vec%0d", i));
      apply($sformatf("vec%0d", i), vecs[i].x, vecs[i].v, vecs[i].len, vecs[i].exp);
    end

    // Counter saturation with L=2 and constant ones
    do_reset("cnt");
    for (int i = 0; i < 20; i++) begin
      apply($sformatf("cnt%0d", i), 1'b1, 1'b1, 4'd2, (i != 0));
    end
    check("cnt sat", int'(pal_count_o), cnt_model());

    // Asynchronous reset in the middle of a cycle
    x_i = 1'b1; valid_i = 1'b1; len_i = 4'd2;
    #2;
    check("mid pal", int'(palindrome_o), 1);
    reset = 1'b0;
    #1;
    check("async pal", int'(palindrome_o), 0);
    check("async cnt", int'(pal_count_o), 0);
    valid_i = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
    apply("post", 1'b1, 1'b1, 4'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
